lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- Load/store initiator in the CPU MEM stage; drives the byte-addressed, little-endian data memory through its Address/WriteData/MemRead/MemWrite interface.
- Converts CPU byte, halfword and word loads/stores into word accesses. Stalls the pipeline while an access is in flight.
- Memory has no byte enables, so sub-word stores are performed as read-modify-write.

Parameters:
- MEM_LAT, 1, cycles MemRead_o is held before ReadData_i is sampled (legal 1..15; 4-bit wait counter).

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-low reset
- req_i  input  1  access request; accepted only when busy_o=0
- we_i  input  1  1=store, 0=load
- size_i  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
- unsigned_i  input  1  load zero-extends when 1, sign-extends when 0
- addr_i  input  32  byte address
- wdata_i  input  32  store data, right-aligned
- busy_o  output  1  high in every non-IDLE state
- done_o  output  1  one-cycle completion pulse
- err_o  output  1  misaligned-access flag, valid with done_o
- rdata_o  output  32  extended load result
- Address_o  output  32  word-aligned memory address ({addr[31:2],2'b00})
- WriteData_o  output  32  memory write word
- MemRead_o  output  1  memory read strobe
- MemWrite_o  output  1  memory write strobe
- ReadData_i  input  32  memory read word

Behaviour:
- Reset: asynchronous, active-low. Forces IDLE and clears all outputs to 0. Strobes drop immediately, including mid-access.
- States: IDLE, RD, WR, DONE. The wait counter is used in RD.
- IDLE, req_i=1:
  - Capture we/size/unsigned/addr/wdata.
  - Next state is RD for a load or a sub-word store, WR for a word store, DONE for a checked error.
- RD:
  - MemRead_o=1, Address_o=aligned address.
  - Stays MEM_LAT cycles.
  - On the last cycle, capture ReadData_i, then go to DONE (load) or WR (sub-word store).
- WR:
  - Exactly one cycle: MemWrite_o=1, Address_o=aligned address.
  - WriteData_o = wdata for a word store.
  - WriteData_o = captured word with the target lane replaced, for a sub-word store.
- DONE: one cycle, done_o=1, rdata_o updated for loads, then return to IDLE.
- Latency, with T = the accepting cycle:
  - load: done at T+MEM_LAT+1
  - word store: WR at T+1, done at T+2
  - sub-word store: WR at T+MEM_LAT+1, done at T+MEM_LAT+2
- Lane selection:
  - byte lane = addr[1:0], bits [8*lane+7 : 8*lane]
  - halfword lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]]
- Load extension: sign-extend or zero-extend per unsigned_i. The word result is unmodified.
- Strobes: MemRead_o and MemWrite_o are never both high. Both are 0 in IDLE and DONE.
- Held values: rdata_o holds until the next load completes; stores do not alter it. Address_o and WriteData_o hold their last value in IDLE.
- Ignored inputs:
  - req_i while busy_o=1 is ignored (no queueing).
  - In-flight accesses use captured values, so input changes during busy have no effect.
- Back-to-back: a request in the cycle after DONE is accepted normally. Minimum issue interval is 2 cycles.

Optional Feature:
- Macro: LSU_MISALIGN_CHK_EN.
- Defined:
  - A halfword with addr[0]=1 or a word with addr[1:0]!=0 is misaligned.
  - Misaligned access goes IDLE→DONE with no strobes. done_o=err_o=1 at T+1; rdata_o unchanged; memory untouched.
- Undefined:
  - err_o is tied 0.
  - Halfword ignores addr[0]; word ignores addr[1:0]. The access proceeds at the aligned address.

Test Plan:
- Preload: 0x10..0x13 = BB,AA,99,88 (word 0x8899AABB); MEM_LAT=1 unless stated.
- lw 0x10 at T → MemRead_o=1 with Address_o=0x10 at T+1 only; done_o at T+2; rdata_o=0x8899AABB; MemWrite_o never high.
- Sub-word loads:
  - lb 0x13 → 0xFFFFFF88
  - lbu 0x13 → 0x00000088
  - lh 0x12 → 0xFFFF8899
  - lhu 0x10 → 0x0000AABB
  - each done at T+2
- sb 0x11 wdata=0x12345677 → read 0x10 at T+1; MemWrite_o at T+2 with WriteData_o=0x889977BB; done at T+3. Re-run with MEM_LAT=3 → write at T+4, done at T+5.
- sw 0x14 0xDEADBEEF → MemWrite_o only at T+1, WriteData_o=0xDEADBEEF, no read; done T+2. Second req_i held during busy is not accepted until after DONE.
- Misaligned lw 0x12:
  - LSU_MISALIGN_CHK_EN defined → done_o=err_o=1 at T+1, no strobes.
  - Undefined → reads 0x10, rdata_o=0x8899AABB, err_o=0.
- MEM_LAT=3, lw in progress, rst_i low during the 2nd RD cycle → MemRead_o and busy_o fall immediately, no done_o, all outputs 0. After release, lw 0x10 completes at T+4 with correct data.

Source files
------------

// File: rtl/lsu_mem_initiator_if.sv
// Word-wide data-memory bus: the load/store initiator drives it (master), the memory answers (slave).
interface lsu_mem_initiator_if;
  logic [31:0] Address_o;
  logic [31:0] WriteData_o;
  logic        MemRead_o;
  logic        MemWrite_o;
  logic [31:0] ReadData_i;

  modport master (
    output Address_o,
    output WriteData_o,
    output MemRead_o,
    output MemWrite_o,
    input  ReadData_i
  );

  modport slave (
    input  Address_o,
    input  WriteData_o,
    input  MemRead_o,
    input  MemWrite_o,
    output ReadData_i
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store initiator: byte/half/word accesses on a word memory, sub-word stores via read-modify-write.
// Load done at T+MEM_LAT+1, word store T+2, sub-word store T+MEM_LAT+2; busy_o blocks new requests; LSU_MISALIGN_CHK_EN adds err_o.
module lsu_mem_initiator #(
  parameter int MEM_LAT = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_i,
  input  logic                       we_i,
  input  logic [1:0]                 size_i,
  input  logic                       unsigned_i,
  input  logic [31:0]                addr_i,
  input  logic [31:0]                wdata_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [31:0]                rdata_o,
  lsu_mem_initiator_if.master        mem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wlo_q, wlo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mwdat_q, mwdat_d;
  logic        misal;

  // Extracts the addressed lane of a fetched word and extends it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] ln, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{ln, 3'b000} +: 8];
    h = w[{ln[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   r = {{24{b[7] & ~uns}}, b};
      2'b01:   r = {{16{h[15] & ~uns}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] ln, input logic [15:0] d);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) r[{ln, 3'b000} +: 8] = d[7:0];
    else             r[{ln[1], 4'b0000} +: 16] = d;
    return r;
  endfunction

`ifdef LSU_MISALIGN_CHK_EN
  logic err_q, err_d;
  assign misal = ((size_i == 2'b01) && addr_i[0]) || (size_i[1] && (addr_i[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    lane_d  = lane_q;
    wlo_d   = wlo_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    maddr_d = maddr_q;
    mwdat_d = mwdat_q;
`ifdef LSU_MISALIGN_CHK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          we_d   = we_i;
          size_d = size_i;
          uns_d  = unsigned_i;
          lane_d = addr_i[1:0];
          wlo_d  = wdata_i[15:0];
          cnt_d  = 4'd0;
          if (misal) begin
            state_d = S_DONE;
`ifdef LSU_MISALIGN_CHK_EN
            err_d   = 1'b1;
`endif
          end else if (we_i && size_i[1]) begin
            state_d = S_WR;
            maddr_d = {addr_i[31:2], 2'b00};
            mwdat_d = wdata_i;
          end else begin
            state_d = S_RD;
            maddr_d = {addr_i[31:2], 2'b00};
          end
        end
      end
      S_RD: begin
        if (cnt_q == LAST_CNT) begin
          if (we_q) begin
            state_d = S_WR;
            mwdat_d = merge_lane(mem.ReadData_i, size_q, lane_q, wlo_q);
          end else begin
            state_d = S_DONE;
            rdata_d = load_ext(mem.ReadData_i, size_q, lane_q, uns_q);
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WR: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
`ifdef LSU_MISALIGN_CHK_EN
        err_d   = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
      wlo_q   <= 16'h0000;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      maddr_q <= 32'h0;
      mwdat_q <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lane_q  <= lane_d;
      wlo_q   <= wlo_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      maddr_q <= maddr_d;
      mwdat_q <= mwdat_d;
    end
  end

`ifdef LSU_MISALIGN_CHK_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Strobes decode straight from state so reset removes them without waiting for a clock.
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = (state_q == S_DONE);
  assign rdata_o         = rdata_q;
  assign mem.MemRead_o   = (state_q == S_RD);
  assign mem.MemWrite_o  = (state_q == S_WR);
  assign mem.Address_o   = maddr_q;
  assign mem.WriteData_o = mwdat_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench: two initiators (MEM_LAT=1 and MEM_LAT=3), each on its own byte-array memory.
module tb_lsu_mem_initiator;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req1, req3, we, uns;
  logic [1:0]  sz;
  logic [31:0] addr, wdata;
  logic        busy1, done1, err1, busy3, done3, err3;
  logic [31:0] rdata1, rdata3;

  lsu_mem_initiator_if m1();
  lsu_mem_initiator_if m3();

  lsu_mem_initiator #(.MEM_LAT(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req1), .we_i(we), .size_i(sz), .unsigned_i(uns),
    .addr_i(addr), .wdata_i(wdata), .busy_o(busy1), .done_o(done1), .err_o(err1),
    .rdata_o(rdata1), .mem(m1)
  );

  lsu_mem_initiator #(.MEM_LAT(3)) dut3 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req3), .we_i(we), .size_i(sz), .unsigned_i(uns),
    .addr_i(addr), .wdata_i(wdata), .busy_o(busy3), .done_o(done3), .err_o(err3),
    .rdata_o(rdata3), .mem(m3)
  );

  always #5 clk = ~clk;

  logic [7:0] mem1 [0:31];
  logic [7:0] mem3 [0:31];

  assign m1.ReadData_i = {mem1[{m1.Address_o[4:2], 2'd3}], mem1[{m1.Address_o[4:2], 2'd2}],
                          mem1[{m1.Address_o[4:2], 2'd1}], mem1[{m1.Address_o[4:2], 2'd0}]};
  assign m3.ReadData_i = {mem3[{m3.Address_o[4:2], 2'd3}], mem3[{m3.Address_o[4:2], 2'd2}],
                          mem3[{m3.Address_o[4:2], 2'd1}], mem3[{m3.Address_o[4:2], 2'd0}]};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem1[i] <= 8'h00;
      mem1[16] <= 8'hBB; mem1[17] <= 8'hAA; mem1[18] <= 8'h99; mem1[19] <= 8'h88;
    end else if (m1.MemWrite_o) begin
      mem1[{m1.Address_o[4:2], 2'd0}] <= m1.WriteData_o[7:0];
      mem1[{m1.Address_o[4:2], 2'd1}] <= m1.WriteData_o[15:8];
      mem1[{m1.Address_o[4:2], 2'd2}] <= m1.WriteData_o[23:16];
      mem1[{m1.Address_o[4:2], 2'd3}] <= m1.WriteData_o[31:24];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem3[i] <= 8'h00;
      mem3[16] <= 8'hBB; mem3[17] <= 8'hAA; mem3[18] <= 8'h99; mem3[19] <= 8'h88;
    end else if (m3.MemWrite_o) begin
      mem3[{m3.Address_o[4:2], 2'd0}] <= m3.WriteData_o[7:0];
      mem3[{m3.Address_o[4:2], 2'd1}] <= m3.WriteData_o[15:8];
      mem3[{m3.Address_o[4:2], 2'd2}] <= m3.WriteData_o[23:16];
      mem3[{m3.Address_o[4:2], 2'd3}] <= m3.WriteData_o[31:24];
    end
  end

  int          n_vec = 0;
  int          n_err = 0;
  int          obs_done, obs_rd_first, obs_rd_n, obs_wr_first, obs_wr_n;
  logic        obs_both, obs_err;
  logic [31:0] obs_rdata, obs_wdat, obs_addr_rd, obs_addr_wr;
  logic [31:0] exp_rd1;

  localparam logic [1:0]  LD_SZ  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
  localparam logic        LD_UNS [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [31:0] LD_AD  [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
  localparam logic [31:0] LD_EXP [4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h0000AABB};

  // Issues one request and records per-cycle activity, k=1 being the cycle after acceptance.
  task automatic xact(input bit sel, input logic w, input logic [1:0] s, input logic u,
                      input logic [31:0] a, input logic [31:0] d);
    logic mr, mw, dn, er;
    logic [31:0] ad, wd, rd;
    @(negedge clk);
    we = w; sz = s; uns = u; addr = a; wdata = d;
    if (sel) req3 = 1'b1; else req1 = 1'b1;
    obs_done = -1; obs_rd_first = -1; obs_rd_n = 0; obs_wr_first = -1; obs_wr_n = 0;
    obs_both = 1'b0; obs_err = 1'bx; obs_rdata = 'x; obs_wdat = 'x;
    obs_addr_rd = 'x; obs_addr_wr = 'x;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req1 = 1'b0; req3 = 1'b0;
      mr = sel ? m3.MemRead_o  : m1.MemRead_o;
      mw = sel ? m3.MemWrite_o : m1.MemWrite_o;
      dn = sel ? done3 : done1;
      er = sel ? err3 : err1;
      ad = sel ? m3.Address_o : m1.Address_o;
      wd = sel ? m3.WriteData_o : m1.WriteData_o;
      rd = sel ? rdata3 : rdata1;
      if (mr) begin if (obs_rd_first < 0) obs_rd_first = k; obs_rd_n++; obs_addr_rd = ad; end
      if (mw) begin if (obs_wr_first < 0) obs_wr_first = k; obs_wr_n++; obs_addr_wr = ad; obs_wdat = wd; end
      if (mr && mw) obs_both = 1'b1;
      if (dn) begin obs_done = k; obs_rdata = rd; obs_err = er; break; end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_vec++;
    if ({busy1, done1, err1, m1.MemRead_o, m1.MemWrite_o, busy3, done3, err3, m3.MemRead_o, m3.MemWrite_o} !== 10'b0) begin
      n_err++; $display("FAIL reset_flags: got %b expected 0", {busy1, done1, err1, m1.MemRead_o, m1.MemWrite_o, busy3, done3, err3, m3.MemRead_o, m3.MemWrite_o});
    end
    n_vec++;
    if ({rdata1, m1.Address_o, m1.WriteData_o} !== 96'h0) begin
      n_err++; $display("FAIL reset_bus1: got %h expected 0", {rdata1, m1.Address_o, m1.WriteData_o});
    end
    n_vec++;
    if ({rdata3, m3.Address_o, m3.WriteData_o} !== 96'h0) begin
      n_err++; $display("FAIL reset_bus3: got %h expected 0", {rdata3, m3.Address_o, m3.WriteData_o});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy1 !== 1'b0) begin n_err++; $display("FAIL idle_after_reset: busy got %b expected 0", busy1); end
  endtask

  task automatic test_word_load;
    xact(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    n_vec++; if (obs_done !== 2) begin n_err++; $display("FAIL lw_done: got %0d expected 2", obs_done); end
    n_vec++; if (obs_rd_first !== 1 || obs_rd_n !== 1) begin n_err++; $display("FAIL lw_read: first %0d n %0d expected 1 1", obs_rd_first, obs_rd_n); end
    n_vec++; if (obs_addr_rd !== 32'h10) begin n_err++; $display("FAIL lw_addr: got %h expected 00000010", obs_addr_rd); end
    n_vec++; if (obs_wr_n !== 0) begin n_err++; $display("FAIL lw_nowrite: got %0d expected 0", obs_wr_n); end
    n_vec++; if (obs_rdata !== 32'h8899AABB) begin n_err++; $display("FAIL lw_data: got %h expected 8899aabb", obs_rdata); end
    exp_rd1 = 32'h8899AABB;
  endtask

  task automatic test_subword_loads;
    for (int i = 0; i < 4; i++) begin
      xact(0, 1'b0, LD_SZ[i], LD_UNS[i], LD_AD[i], 32'h0);
      n_vec++;
      if (obs_done !== 2 || obs_rdata !== LD_EXP[i]) begin
        n_err++; $display("FAIL subload%0d: done %0d data %h expected 2 %h", i, obs_done, obs_rdata, LD_EXP[i]);
      end
      exp_rd1 = LD_EXP[i];
    end
  endtask

  task automatic test_misaligned;
    xact(0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
`ifdef LSU_MISALIGN_CHK_EN
    n_vec++; if (obs_done !== 1 || obs_err !== 1'b1) begin n_err++; $display("FAIL misal_err: done %0d err %b expected 1 1", obs_done, obs_err); end
    n_vec++; if (obs_rd_n !== 0 || obs_wr_n !== 0) begin n_err++; $display("FAIL misal_strobes: rd %0d wr %0d expected 0 0", obs_rd_n, obs_wr_n); end
    n_vec++; if (obs_rdata !== exp_rd1) begin n_err++; $display("FAIL misal_rdata: got %h expected %h", obs_rdata, exp_rd1); end
`else
    n_vec++; if (obs_done !== 2 || obs_err !== 1'b0) begin n_err++; $display("FAIL misal_done: done %0d err %b expected 2 0", obs_done, obs_err); end
    n_vec++; if (obs_addr_rd !== 32'h10) begin n_err++; $display("FAIL misal_addr: got %h expected 00000010", obs_addr_rd); end
    n_vec++; if (obs_rdata !== 32'h8899AABB) begin n_err++; $display("FAIL misal_rdata: got %h expected 8899aabb", obs_rdata); end
    exp_rd1 = 32'h8899AABB;
`endif
  endtask

  task automatic test_subword_store;
    xact(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h12345677);
    n_vec++; if (obs_rd_first !== 1 || obs_wr_first !== 2 || obs_wr_n !== 1) begin
      n_err++; $display("FAIL sb_seq: rd %0d wr %0d nwr %0d expected 1 2 1", obs_rd_first, obs_wr_first, obs_wr_n); end
    n_vec++; if (obs_wdat !== 32'h889977BB || obs_addr_wr !== 32'h10) begin
      n_err++; $display("FAIL sb_word: data %h addr %h expected 889977bb 00000010", obs_wdat, obs_addr_wr); end
    n_vec++; if (obs_done !== 3 || obs_both !== 1'b0) begin n_err++; $display("FAIL sb_done: done %0d both %b expected 3 0", obs_done, obs_both); end
    n_vec++; if (obs_rdata !== exp_rd1) begin n_err++; $display("FAIL sb_rdata_hold: got %h expected %h", obs_rdata, exp_rd1); end
    xact(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    n_vec++; if (obs_rdata !== 32'h889977BB) begin n_err++; $display("FAIL sb_readback: got %h expected 889977bb", obs_rdata); end
    exp_rd1 = 32'h889977BB;
    xact(1, 1'b1, 2'b00, 1'b0, 32'h11, 32'h12345677);
    n_vec++; if (obs_rd_n !== 3 || obs_wr_first !== 4 || obs_done !== 5) begin
      n_err++; $display("FAIL sb_lat3: nrd %0d wr %0d done %0d expected 3 4 5", obs_rd_n, obs_wr_first, obs_done); end
    n_vec++; if (obs_wdat !== 32'h889977BB) begin n_err++; $display("FAIL sb_lat3_word: got %h expected 889977bb", obs_wdat); end
  endtask

  task automatic test_word_store;
    int rd_n, dn_n;
    logic [31:0] rdv;
    xact(0, 1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF);
    n_vec++; if (obs_wr_first !== 1 || obs_wr_n !== 1 || obs_rd_n !== 0) begin
      n_err++; $display("FAIL sw_seq: wr %0d nwr %0d nrd %0d expected 1 1 0", obs_wr_first, obs_wr_n, obs_rd_n); end
    n_vec++; if (obs_wdat !== 32'hDEADBEEF || obs_addr_wr !== 32'h14) begin
      n_err++; $display("FAIL sw_word: data %h addr %h expected deadbeef 00000014", obs_wdat, obs_addr_wr); end
    n_vec++; if (obs_done !== 2) begin n_err++; $display("FAIL sw_done: got %0d expected 2", obs_done); end
    // Request held high through RD and DONE, address changed mid-flight.
    @(negedge clk);
    we = 1'b0; sz = 2'b10; uns = 1'b0; addr = 32'h14; req1 = 1'b1;
    rd_n = 0; dn_n = 0; rdv = 'x;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (m1.MemRead_o) rd_n++;
      if (done1) begin dn_n++; rdv = rdata1; end
      if (k == 1) addr = 32'h10;
      if (k == 3) req1 = 1'b0;
    end
    n_vec++; if (rd_n !== 1 || dn_n !== 1) begin n_err++; $display("FAIL held_req: reads %0d dones %0d expected 1 1", rd_n, dn_n); end
    n_vec++; if (rdv !== 32'hDEADBEEF) begin n_err++; $display("FAIL held_capture: got %h expected deadbeef", rdv); end
  endtask

  task automatic test_back_to_back;
    xact(0, 1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
    n_vec++; if (obs_done !== 2 || obs_rdata !== 32'h00000099) begin
      n_err++; $display("FAIL b2b_first: done %0d data %h expected 2 00000099", obs_done, obs_rdata); end
    xact(0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    n_vec++; if (obs_done !== 2 || obs_rdata !== 32'h000077BB) begin
      n_err++; $display("FAIL b2b_second: done %0d data %h expected 2 000077bb", obs_done, obs_rdata); end
  endtask

  task automatic test_reset_midflight;
    int dn_n;
    @(negedge clk);
    we = 1'b0; sz = 2'b10; uns = 1'b0; addr = 32'h10; req3 = 1'b1;
    @(negedge clk);
    req3 = 1'b0;
    @(negedge clk);
    n_vec++; if (m3.MemRead_o !== 1'b1) begin n_err++; $display("FAIL rst_pre_read: got %b expected 1", m3.MemRead_o); end
    rst_n = 1'b0;
    #1;
    n_vec++; if ({busy3, done3, err3, m3.MemRead_o, m3.MemWrite_o} !== 5'b0) begin
      n_err++; $display("FAIL rst_mid_flags: got %b expected 0", {busy3, done3, err3, m3.MemRead_o, m3.MemWrite_o}); end
    n_vec++; if ({rdata3, m3.Address_o, m3.WriteData_o} !== 96'h0) begin
      n_err++; $display("FAIL rst_mid_bus: got %h expected 0", {rdata3, m3.Address_o, m3.WriteData_o}); end
    dn_n = 0;
    repeat (3) begin @(negedge clk); if (done3) dn_n++; end
    n_vec++; if (dn_n !== 0) begin n_err++; $display("FAIL rst_mid_nodone: got %0d expected 0", dn_n); end
    rst_n = 1'b1;
    xact(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    n_vec++; if (obs_done !== 4 || obs_rd_n !== 3) begin
      n_err++; $display("FAIL rst_after_lw: done %0d nrd %0d expected 4 3", obs_done, obs_rd_n); end
    n_vec++; if (obs_rdata !== 32'h8899AABB) begin n_err++; $display("FAIL rst_after_data: got %h expected 8899aabb", obs_rdata); end
  endtask

  initial begin
    rst_n = 1'b0; req1 = 1'b0; req3 = 1'b0; we = 1'b0; sz = 2'b00; uns = 1'b0;
    addr = 32'h0; wdata = 32'h0; exp_rd1 = 32'h0;
    repeat (2) @(negedge clk);
    test_reset();
    test_word_load();
    test_subword_loads();
    test_misaligned();
    test_subword_store();
    test_word_store();
    test_back_to_back();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
